// File: rtl/cic_pkg.sv
// Shared elaboration-time helpers for the CIC interpolator.
//   clog2_int  : ceiling log2 of a positive integer
//   is_pow2    : true when the argument is a positive power of two
//   cic_width  : internal datapath width W = bits + m*log2(r) + 1
//   cic_shift  : right shift that normalises the DC gain r^(m-1) back to 1
package cic_pkg;

   function automatic int clog2_int(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic int cic_width(input int bits, input int m, input int r);
      return bits + m * clog2_int(r) + 1;
   endfunction

   function automatic int cic_shift(input int m, input int r);
      return (m - 1) * clog2_int(r);
   endfunction

endpackage

// File: rtl/cic_interp_axis_if.sv
// Stream bundle for the CIC interpolator: low-rate input stream, full-rate
// output stream and the underflow sideband.
//   slave  : the interpolator's view (consumes S_AXIS_*, produces M_AXIS_*)
//   master : the surrounding logic's view (drives S_AXIS_*, observes the rest)
//
// Handshake: an input transfer happens on a rising clk edge where both
// S_AXIS_tvalid and S_AXIS_tready are high. tready rises for exactly one
// cycle in R and never depends on tvalid; an upstream that sees tready low
// must hold its sample. The output side has no ready: M_AXIS_tvalid, once
// high, stays high and every clock carries a new sample.
interface cic_interp_axis_if #(
   parameter int AXIS_TDATA_WIDTH = 32
);
   logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
   logic                        S_AXIS_tvalid;
   logic                        S_AXIS_tready;
   logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;
   logic                        M_AXIS_tvalid;
   logic                        underflow;

   modport slave (
      input  S_AXIS_tdata, S_AXIS_tvalid,
      output S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, underflow
   );

   modport master (
      output S_AXIS_tdata, S_AXIS_tvalid,
      input  S_AXIS_tready, M_AXIS_tdata, M_AXIS_tvalid, underflow
   );
endinterface

// File: rtl/cic_interp_axis_integrator_chain.sv
// M cascaded W-bit accumulators running every clock at the full rate.
//   clk, rst : clock and synchronous active-high reset (clears all stages)
//   u        : zero-stuffed input, added into the first stage every cycle
//   acc_out  : last stage value
// All sums wrap modulo 2^W; that wrap is what lets the comb section cancel
// the integrator growth exactly.
module cic_integrator_chain #(
   parameter int W = 25,
   parameter int M = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] u,
   output logic signed [W-1:0] acc_out
);

   logic signed [W-1:0] acc [M];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < M; i++) acc[i] <= '0;
      end else begin
         acc[0] <= acc[0] + u;
         // Each stage adds the previous stage's value from before this edge.
         for (int i = 1; i < M; i++) acc[i] <= acc[i] + acc[i-1];
      end
   end

   assign acc_out = acc[M-1];

endmodule

// File: rtl/cic_interp_axis.sv
// Single-channel CIC interpolator with AXI-Stream style ports.
// Accepts one sample every R clocks, runs M comb stages at the low rate,
// zero-stuffs to the clock rate, integrates with M stages and emits one
// gain-normalised sample per clock.
//   clk  : sole clock
//   rst  : synchronous active-high reset
//   axis : S_AXIS_tdata/tvalid/tready (low-rate input, bits [BIT_LENGTH-1:0]
//          used), M_AXIS_tdata/tvalid (full-rate output, upper bits
//          sign-extended when SE=1, zero otherwise), underflow (one-cycle
//          pulse when an accept slot passes without tvalid)
module cic_interp_axis
   import cic_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int BIT_LENGTH       = 14,
   parameter int R                = 32,
   parameter int M                = 2,
   parameter int SE               = 0
) (
   input logic            clk,
   input logic            rst,
   cic_interp_axis_if.slave axis
);

   localparam int LOG2R = clog2_int(R);
   localparam int W     = cic_width(BIT_LENGTH, M, R);
   localparam int SHIFT = cic_shift(M, R);

   if (!is_pow2(R) || (R < M + 2) || (M < 1)) begin : g_bad_params
      $error("cic_interp_axis: R must be a power of two, R >= M+2 and M >= 1");
   end

   logic [LOG2R-1:0]            p;
   logic                        slot;
   logic signed [BIT_LENGTH-1:0] x_in;
   logic signed [W-1:0]         x;
   logic signed [W-1:0]         comb_chain [M+1];
   logic signed [W-1:0]         u;
   logic signed [W-1:0]         i_out;
   logic [BIT_LENGTH-1:0]       y;
   logic [2*M+1:0]              vld_pipe;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_fmt;
   logic                        unused_tdata;
   logic                        unused_acc;

   // Free-running phase; R is a power of two so the natural wrap is 0..R-1.
   always_ff @(posedge clk) begin
      if (rst) p <= '0;
      else     p <= p + 1'b1;
   end

   assign slot = (p == '0);
   assign x_in = axis.S_AXIS_tdata[BIT_LENGTH-1:0];

   // A missing sample at the slot is treated as a zero input.
   always_ff @(posedge clk) begin
      if (rst) begin
         x <= '0;
      end else if (slot) begin
         if (axis.S_AXIS_tvalid) x <= {{(W-BIT_LENGTH){x_in[BIT_LENGTH-1]}}, x_in};
         else                    x <= '0;
      end
   end

   // Comb stage j fires on phase j only, so each sample ripples through the
   // M stages on consecutive cycles right after it is captured.
   assign comb_chain[0] = x;

   for (genvar j = 1; j <= M; j++) begin : g_comb
      logic signed [W-1:0] c_q;
      logic signed [W-1:0] d_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            c_q <= '0;
            d_q <= '0;
         end else if (p == LOG2R'(j)) begin
            c_q <= comb_chain[j-1] - d_q;
            d_q <= comb_chain[j-1];
         end
      end

      assign comb_chain[j] = c_q;
   end

   // Zero-stuffing: the comb result enters the integrators for one cycle.
   assign u = (p == LOG2R'(M + 1)) ? comb_chain[M] : '0;

   cic_integrator_chain #(
      .W (W),
      .M (M)
   ) u_integ (
      .clk     (clk),
      .rst     (rst),
      .u       (u),
      .acc_out (i_out)
   );

   // Arithmetic shift by SHIFT followed by truncation to BIT_LENGTH bits is
   // just this slice; no saturation, out-of-range results wrap.
   always_ff @(posedge clk) begin
      if (rst) y <= '0;
      else     y <= i_out[SHIFT +: BIT_LENGTH];
   end

   // Marker launched on the first accept edge; it reaches the top bit on the
   // same edge the first sample reaches y (2M+1 edges later) and then stays.
   always_ff @(posedge clk) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[2*M:0], vld_pipe[0] | slot};
   end

   always_comb begin
      tdata_fmt = '0;
      tdata_fmt[BIT_LENGTH-1:0] = y;
      if ((SE != 0) && y[BIT_LENGTH-1]) tdata_fmt[AXIS_TDATA_WIDTH-1:BIT_LENGTH] = '1;
   end

   // Outputs are forced quiet while rst is high, not only after the reset edge.
   assign axis.S_AXIS_tready = slot & ~rst;
   assign axis.underflow     = slot & ~rst & ~axis.S_AXIS_tvalid;
   assign axis.M_AXIS_tvalid = vld_pipe[2*M+1] & ~rst;
   assign axis.M_AXIS_tdata  = rst ? '0 : tdata_fmt;

   // Upper tdata bits and the integrator bits outside the output window are
   // intentionally dropped.
   assign unused_tdata = ^axis.S_AXIS_tdata;
   assign unused_acc   = ^i_out;

endmodule
